// File: rtl/draw_sequencer.sv
// Rectangle-fill sequencer: walks a w x h box row-major and issues one plot
// instruction per pixel. Define DRAW_SEQ_READBACK_EN to precede each plot with a memory read.
module draw_sequencer #(
    parameter int unsigned X_COORD_WIDTH     = 8,
    parameter int unsigned Y_COORD_WIDTH     = 7,
    parameter int unsigned COLOUR_WIDTH      = 3,
    parameter int unsigned MEM_ADDR_WIDTH    = 16,
    parameter int unsigned RESULT_WIDTH      = 16,
    parameter int unsigned OPCODE_WIDTH      = 4,
    parameter int unsigned INSTRUCTION_WIDTH = 24,
    parameter int unsigned OPCODE_PLOT       = 1,
    parameter int unsigned OPCODE_READ       = 2
) (
    input  logic                         clock,
    input  logic                         resetn,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [X_COORD_WIDTH-1:0]     cmd_x0,
    input  logic [Y_COORD_WIDTH-1:0]     cmd_y0,
    input  logic [X_COORD_WIDTH-1:0]     cmd_w,
    input  logic [Y_COORD_WIDTH-1:0]     cmd_h,
    input  logic [COLOUR_WIDTH-1:0]      cmd_colour,
    input  logic [MEM_ADDR_WIDTH-1:0]    cmd_base,
    output logic                         start,
    output logic [INSTRUCTION_WIDTH-1:0] instruction,
    input  logic                         finished,
    input  logic [RESULT_WIDTH-1:0]      result,
    output logic                         busy,
    output logic                         done
);

    localparam int unsigned X_LSB      = 0;
    localparam int unsigned Y_LSB      = 8;
    localparam int unsigned COLOUR_LSB = 15;
    localparam int unsigned PLOT_BIT   = 18;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RDY,
        ISSUE,
        ACK,
        WAIT_FIN,
        NEXT
    } state_t;

    state_t                         state_q, state_d;
    logic [X_COORD_WIDTH-1:0]       x0_q, x0_d, w_q, w_d, i_q, i_d;
    logic [Y_COORD_WIDTH-1:0]       y0_q, y0_d, h_q, h_d, j_q, j_d;
    logic                           start_q, start_d;
    logic                           done_q, done_d;
    logic [INSTRUCTION_WIDTH-1:0]   instr_q, instr_d;
    logic [INSTRUCTION_WIDTH-1:0]   plot_instr;
    logic [INSTRUCTION_WIDTH-1:0]   issue_instr;
    logic                           last_pixel;
    logic                           pixel_done;

`ifdef DRAW_SEQ_READBACK_EN
    logic [MEM_ADDR_WIDTH-1:0]      base_q, base_d, idx_q, idx_d;
    logic                           phase_q, phase_d;
    logic [COLOUR_WIDTH:0]          rb_q, rb_d;
    logic [INSTRUCTION_WIDTH-1:0]   read_instr;
    logic                           unused_ok;

    assign unused_ok = ^{cmd_colour, result[RESULT_WIDTH-1:COLOUR_WIDTH+1]};
`else
    logic [COLOUR_WIDTH-1:0]        colour_q, colour_d;
    logic                           unused_ok;

    assign unused_ok = ^{cmd_base, result};
`endif

    always_comb begin
        plot_instr = '0;
        plot_instr[INSTRUCTION_WIDTH-1 -: OPCODE_WIDTH] = OPCODE_PLOT[OPCODE_WIDTH-1:0];
        plot_instr[X_LSB +: X_COORD_WIDTH] = x0_q + i_q;
        plot_instr[Y_LSB +: Y_COORD_WIDTH] = y0_q + j_q;
`ifdef DRAW_SEQ_READBACK_EN
        // Colour and plot enable come from the word fetched for this pixel.
        plot_instr[COLOUR_LSB +: COLOUR_WIDTH] = rb_q[COLOUR_WIDTH-1:0];
        plot_instr[PLOT_BIT] = ~rb_q[COLOUR_WIDTH];
        read_instr = '0;
        read_instr[INSTRUCTION_WIDTH-1 -: OPCODE_WIDTH] = OPCODE_READ[OPCODE_WIDTH-1:0];
        read_instr[MEM_ADDR_WIDTH-1:0] = base_q + idx_q;
        issue_instr = phase_q ? plot_instr : read_instr;
        pixel_done  = phase_q;
`else
        plot_instr[COLOUR_LSB +: COLOUR_WIDTH] = colour_q;
        plot_instr[PLOT_BIT] = 1'b1;
        issue_instr = plot_instr;
        pixel_done  = 1'b1;
`endif
        last_pixel = (i_q == w_q - 1'b1) && (j_q == h_q - 1'b1);
    end

    always_comb begin
        state_d = state_q;
        x0_d    = x0_q;
        y0_d    = y0_q;
        w_d     = w_q;
        h_d     = h_q;
        i_d     = i_q;
        j_d     = j_q;
        start_d = 1'b0;
        done_d  = 1'b0;
        instr_d = instr_q;
`ifdef DRAW_SEQ_READBACK_EN
        base_d  = base_q;
        idx_d   = idx_q;
        phase_d = phase_q;
        rb_d    = rb_q;
`else
        colour_d = colour_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    x0_d = cmd_x0;
                    y0_d = cmd_y0;
                    w_d  = cmd_w;
                    h_d  = cmd_h;
                    i_d  = '0;
                    j_d  = '0;
`ifdef DRAW_SEQ_READBACK_EN
                    base_d  = cmd_base;
                    idx_d   = '0;
                    phase_d = 1'b0;
`else
                    colour_d = cmd_colour;
`endif
                    // An empty box finishes immediately without touching the datapath.
                    if (cmd_w == '0 || cmd_h == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = WAIT_RDY;
                    end
                end
            end
            WAIT_RDY: begin
                if (finished) begin
                    state_d = ISSUE;
                    start_d = 1'b1;
                    instr_d = issue_instr;
                end
            end
            ISSUE: state_d = ACK;
            ACK:   state_d = WAIT_FIN;
            WAIT_FIN: begin
                if (finished) begin
                    state_d = NEXT;
`ifdef DRAW_SEQ_READBACK_EN
                    if (!phase_q) begin
                        rb_d = result[COLOUR_WIDTH:0];
                    end
`endif
                end
            end
            NEXT: begin
                state_d = WAIT_RDY;
`ifdef DRAW_SEQ_READBACK_EN
                phase_d = ~phase_q;
`endif
                if (pixel_done) begin
`ifdef DRAW_SEQ_READBACK_EN
                    idx_d = idx_q + 1'b1;
`endif
                    if (last_pixel) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else if (i_q == w_q - 1'b1) begin
                        i_d = '0;
                        j_d = j_q + 1'b1;
                    end else begin
                        i_d = i_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset abandons the command; an instruction already in the datapath runs on.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q <= IDLE;
            x0_q    <= '0;
            y0_q    <= '0;
            w_q     <= '0;
            h_q     <= '0;
            i_q     <= '0;
            j_q     <= '0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
            instr_q <= '0;
`ifdef DRAW_SEQ_READBACK_EN
            base_q  <= '0;
            idx_q   <= '0;
            phase_q <= 1'b0;
            rb_q    <= '0;
`else
            colour_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            x0_q    <= x0_d;
            y0_q    <= y0_d;
            w_q     <= w_d;
            h_q     <= h_d;
            i_q     <= i_d;
            j_q     <= j_d;
            start_q <= start_d;
            done_q  <= done_d;
            instr_q <= instr_d;
`ifdef DRAW_SEQ_READBACK_EN
            base_q  <= base_d;
            idx_q   <= idx_d;
            phase_q <= phase_d;
            rb_q    <= rb_d;
`else
            colour_q <= colour_d;
`endif
        end
    end

    assign cmd_ready   = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign start       = start_q;
    assign instruction = instr_q;
    assign done        = done_q;

endmodule

// File: tb/tb_draw_sequencer.sv
// Bench for draw_sequencer: a toy datapath, a pixel-list scoreboard built from
// the command fields, and directed rectangle commands.
module tb_draw_sequencer;

    logic        clock = 1'b0;
    logic        resetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_x0;
    logic [6:0]  cmd_y0;
    logic [7:0]  cmd_w;
    logic [6:0]  cmd_h;
    logic [2:0]  cmd_colour;
    logic [15:0] cmd_base;
    logic        start;
    logic [23:0] instruction;
    logic        finished;
    logic [15:0] result;
    logic        busy;
    logic        done;

    always #5 clock = ~clock;

    draw_sequencer dut (
        .clock       (clock),
        .resetn      (resetn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_x0      (cmd_x0),
        .cmd_y0      (cmd_y0),
        .cmd_w       (cmd_w),
        .cmd_h       (cmd_h),
        .cmd_colour  (cmd_colour),
        .cmd_base    (cmd_base),
        .start       (start),
        .instruction (instruction),
        .finished    (finished),
        .result      (result),
        .busy        (busy),
        .done        (done)
    );

    int          total = 0;
    int          bad = 0;
    int          dp_cnt = 0;
    logic        hold_low = 1'b0;
    logic        check_en = 1'b0;
    logic        prev_start = 1'b0;
    logic        accept_done = 1'b0;
    int          starts_seen = 0;
    int          dones_seen = 0;
    int          exp_done = 0;
    int          last_latency = 0;
    logic [23:0] exp_q[$];
    logic [23:0] plot_log[$];
    logic [23:0] start_log[$];

    // Datapath: finished drops for two cycles after each start.
    assign finished = (dp_cnt == 0) && !hold_low;

    function automatic logic [15:0] rb_fn(int addr);
        if (addr == 'h0100) return 16'h0005;
        if (addr == 'h0101) return 16'h000C;
        return 16'((addr * 7 + 3) & 'hF);
    endfunction

    always @(posedge clock) begin
        if (start) begin
            dp_cnt <= 2;
            if (instruction[23:20] == 4'h2) result <= rb_fn(int'(instruction[15:0]));
        end else if (dp_cnt > 0) begin
            dp_cnt <= dp_cnt - 1;
        end
    end

    function automatic logic [23:0] mk_plot(int x, int y, int c, int p);
        return 24'('h100000 + ((p & 1) << 18) + ((c & 7) << 15) + ((y & 'h7F) << 8) + (x & 'hFF));
    endfunction

    function automatic logic [23:0] mk_read(int addr);
        return 24'('h200000 + (addr & 'hFFFF));
    endfunction

    task automatic check_output(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard compare, every cycle once out of reset.
    always @(negedge clock) begin
        if (check_en) begin
            check_output("ready_is_not_busy", cmd_ready, !busy);
            if (start) begin
                starts_seen++;
                start_log.push_back(instruction);
                if (instruction[23:20] == 4'h1) plot_log.push_back(instruction);
                check_output("start_one_cycle", prev_start, 0);
                check_output("start_when_finished", finished, 1);
                check_output("start_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) check_output("instruction", instruction, exp_q.pop_front());
            end
            if (done) begin
                dones_seen++;
                check_output("done_expected", exp_done > 0, 1);
                check_output("done_all_issued", exp_q.size(), 0);
                if (exp_done > 0) exp_done--;
            end
            prev_start = start;
        end
    end

    task automatic apply_stimulus(int x0, int y0, int w, int h, int col, int base);
        int tries = 0;
        @(negedge clock);
        cmd_x0     = x0[7:0];
        cmd_y0     = y0[6:0];
        cmd_w      = w[7:0];
        cmd_h      = h[6:0];
        cmd_colour = col[2:0];
        cmd_base   = base[15:0];
        cmd_valid  = 1'b1;
        while (!cmd_ready && tries < 300) begin
            @(negedge clock);
            tries++;
        end
        check_output("accept_in_time", cmd_ready, 1);
        accept_done = done;
        @(posedge clock);
        for (int j = 0; j < h; j++) begin
            for (int i = 0; i < w; i++) begin
`ifdef DRAW_SEQ_READBACK_EN
                int a;
                int r;
                a = (base + j * w + i) & 'hFFFF;
                r = int'(rb_fn(a));
                exp_q.push_back(mk_read(a));
                exp_q.push_back(mk_plot(x0 + i, y0 + j, r & 7, ((r >> 3) & 1) ^ 1));
`else
                exp_q.push_back(mk_plot(x0 + i, y0 + j, col, 1));
`endif
            end
        end
        exp_done++;
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_done(int npix);
        int base_dones = dones_seen;
        int cyc = 0;
        int bound;
`ifdef DRAW_SEQ_READBACK_EN
        bound = 2 * npix * 6 + 1;
`else
        bound = npix * 6 + 1;
`endif
        while (dones_seen == base_dones && cyc < bound + 20) begin
            @(negedge clock);
            #1;
            cyc++;
        end
        last_latency = cyc;
        check_output("done_seen", dones_seen != base_dones, 1);
        check_output("done_latency_ok", cyc <= bound, 1);
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int s0;
        int tries;
        resetn = 1'b0;
        cmd_valid = 1'b0;
        cmd_x0 = '0;
        cmd_y0 = '0;
        cmd_w = '0;
        cmd_h = '0;
        cmd_colour = '0;
        cmd_base = '0;
        result = 16'h000F;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_output("reset_ready", cmd_ready, 1);
        check_output("reset_busy", busy, 0);
        check_output("reset_start", start, 0);
        check_output("reset_done", done, 0);
        check_output("reset_instr", instruction, 0);
        resetn = 1'b1;
        check_en = 1'b1;

        $display("[TB] 2x2 box at (10,5)");
        plot_log.delete();
        apply_stimulus(10, 5, 2, 2, 3, 0);
        wait_done(4);
        check_output("box_plots", plot_log.size(), 4);
        if (plot_log.size() == 4) begin
            check_output("box_p0_xy", plot_log[0][14:0], 15'h050A);
            check_output("box_p1_xy", plot_log[1][14:0], 15'h050B);
            check_output("box_p2_xy", plot_log[2][14:0], 15'h060A);
            check_output("box_p3_xy", plot_log[3][14:0], 15'h060B);
`ifndef DRAW_SEQ_READBACK_EN
            check_output("box_p0", plot_log[0], 24'h15850A);
            check_output("box_p3", plot_log[3], 24'h15860B);
`endif
        end

        $display("[TB] empty box");
        s0 = starts_seen;
        apply_stimulus(3, 3, 0, 4, 1, 0);
        wait_done(0);
        check_output("empty_latency", last_latency, 1);
        check_output("empty_ready", cmd_ready, 1);
        check_output("empty_busy", busy, 0);
        check_output("empty_no_start", starts_seen, s0);

        $display("[TB] x wrap");
        plot_log.delete();
        apply_stimulus(255, 7, 2, 1, 6, 0);
        wait_done(2);
        check_output("wrap_plots", plot_log.size(), 2);
        if (plot_log.size() == 2) begin
            check_output("wrap_x0", plot_log[0][7:0], 255);
            check_output("wrap_x1", plot_log[1][7:0], 0);
        end

        $display("[TB] datapath busy at accept");
        hold_low = 1'b1;
        s0 = starts_seen;
        apply_stimulus(1, 2, 1, 1, 2, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            #1 check_output("hold_no_start", start, 0);
        end
        check_output("hold_start_count", starts_seen, s0);
        hold_low = 1'b0;
        wait_done(1);

        $display("[TB] command offered while busy");
        apply_stimulus(40, 20, 1, 1, 5, 0);
        apply_stimulus(41, 21, 2, 1, 7, 0);
        check_output("accept_in_done_cycle", accept_done, 1);
        wait_done(2);

`ifdef DRAW_SEQ_READBACK_EN
        $display("[TB] readback 1x2 at base 0x0100");
        start_log.delete();
        apply_stimulus(0, 0, 1, 2, 6, 'h0100);
        wait_done(2);
        check_output("rb_count", start_log.size(), 4);
        if (start_log.size() == 4) begin
            check_output("rb_read0", start_log[0], 24'h200100);
            check_output("rb_plot0", start_log[1], 24'h168000);
            check_output("rb_read1", start_log[2], 24'h200101);
            check_output("rb_plot1", start_log[3], 24'h120100);
        end
`endif

        $display("[TB] reset mid-command");
        s0 = starts_seen;
        apply_stimulus(20, 30, 2, 2, 1, 0);
        tries = 0;
        while (starts_seen < s0 + 2 && tries < 100) begin
            @(negedge clock);
            #1;
            tries++;
        end
        check_output("second_start_seen", starts_seen, s0 + 2);
        resetn = 1'b0;
        exp_q.delete();
        exp_done = 0;
        @(negedge clock);
        #1;
        check_output("midreset_start", start, 0);
        check_output("midreset_ready", cmd_ready, 1);
        check_output("midreset_busy", busy, 0);
        check_output("midreset_instr", instruction, 0);
        resetn = 1'b1;
        repeat (20) @(negedge clock);
        #1;
        check_output("midreset_no_more_starts", starts_seen, s0 + 2);
        check_output("midreset_idle", cmd_ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
